// File: rtl/rsa_exp_seq.sv
// rtl/rsa_exp_seq.sv - square-and-multiply sequencer for the modular exponentiation datapath
// Scans the captured exponent MSB-first and sequences one shared multiplier operation at a time.
module rsa_exp_seq #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] exponent,
   input  logic             mul_done,
   output logic             mul_start,
   output logic [1:0]       sel_a,
   output logic [1:0]       sel_b,
   output logic             load_result,
   output logic             busy,
   output logic             done
);

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] SEL_ONE  = 2'b00;
   localparam logic [1:0] SEL_M    = 2'b01;
   localparam logic [1:0] SEL_R    = 2'b10;
   localparam logic [1:0] SEL_ZERO = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      OP_INIT,
      OP_SQ,
      OP_MUL
   } op_t;

   state_t           state_q, state_d;
   op_t              op_q, op_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic [WIDTH-1:0] exp_q, exp_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= OP_INIT;
         bit_q   <= '0;
         exp_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         bit_q   <= bit_d;
         exp_q   <= exp_d;
      end
   end

   // Next op is chosen on the cycle mul_done is seen, so ISSUE follows with no gap.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      bit_d   = bit_q;
      exp_d   = exp_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               exp_d   = exponent;
               op_d    = OP_INIT;
               bit_d   = BW'(WIDTH - 1);
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mul_done) begin
               case (op_q)
                  OP_INIT: begin
                     op_d    = OP_SQ;
                     state_d = S_ISSUE;
                  end
                  OP_SQ: begin
                     if (exp_q[bit_q]) begin
                        op_d    = OP_MUL;
                        state_d = S_ISSUE;
                     end else if (bit_q == '0) begin
                        state_d = S_DONE;
                     end else begin
                        bit_d   = bit_q - BW'(1);
                        op_d    = OP_SQ;
                        state_d = S_ISSUE;
                     end
                  end
                  OP_MUL: begin
                     if (bit_q == '0) begin
                        state_d = S_DONE;
                     end else begin
                        bit_d   = bit_q - BW'(1);
                        op_d    = OP_SQ;
                        state_d = S_ISSUE;
                     end
                  end
                  default: begin
                     state_d = S_IDLE;
                  end
               endcase
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decode only registered state, so an async reset clears them at once.
   always_comb begin
      mul_start   = (state_q == S_ISSUE);
      busy        = (state_q == S_ISSUE) || (state_q == S_WAIT);
      done        = (state_q == S_DONE);
      load_result = (state_q == S_WAIT) && mul_done;
      sel_a       = SEL_ZERO;
      sel_b       = SEL_ZERO;
      if (busy) begin
         case (op_q)
            OP_INIT: begin
               sel_a = SEL_ONE;
               sel_b = SEL_ONE;
            end
            OP_SQ: begin
               sel_a = SEL_R;
               sel_b = SEL_R;
            end
            OP_MUL: begin
               sel_a = SEL_R;
               sel_b = SEL_M;
            end
            default: begin
               sel_a = SEL_ZERO;
               sel_b = SEL_ZERO;
            end
         endcase
      end
   end

endmodule

// File: doc/rsa_exp_seq.md
# rsa_exp_seq

Square-and-multiply sequencer for the modular exponentiation datapath. It scans a WIDTH-bit exponent MSB-first and drives the two operand-select muxes in front of the shared modular multiplier, one operation at a time. For each operation it issues a start pulse, waits for the multiplier's done, and strobes the result register. It sits between the top-level command logic (start/done) and the multiplier plus its operand muxes. Mux select encoding: 00 = constant one, 01 = message register M (mux input a), 10 = result register R (mux input b), 11 = zero.

## Interface
- WIDTH, 10: exponent and datapath width; bit counter is clog2(WIDTH) bits.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request exponentiation; sampled only in IDLE.
- exponent  in  WIDTH  exponent; captured into an internal register on the edge that accepts start.
- mul_done  in  1  multiplier result valid; sampled only in WAIT.
- mul_start  out  1  one-cycle multiplier launch pulse.
- sel_a  out  2  operand-A mux select.
- sel_b  out  2  operand-B mux select.
- load_result  out  1  R-register write enable; combinational, equal to (state==WAIT && mul_done).
- busy  out  1  high in ISSUE and WAIT.
- done  out  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE: on start=1, capture exponent, set op=INIT, set bit=WIDTH-1, go to ISSUE.
  - ISSUE: mul_start=1 for exactly one cycle, then go to WAIT.
  - WAIT: hold outputs until mul_done=1. On that cycle, choose the next op and go to ISSUE, or go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Ops and selects (held constant through ISSUE and WAIT):
  - INIT: sel_a=00, sel_b=00 (R := 1).
  - SQ: sel_a=10, sel_b=10 (R := R·R).
  - MUL: sel_a=10, sel_b=01 (R := R·M).
- Next-op rule on mul_done:
  - After INIT: SQ.
  - After SQ: MUL if exponent_reg[bit]=1. Otherwise, if bit==0 go to DONE, else decrement bit and go to SQ.
  - After MUL: if bit==0 go to DONE, else decrement bit and go to SQ.
- All WIDTH bits are processed, including leading zeros. Operation count is 1 + WIDTH + popcount(exponent).
- Exponent 0: result is 1, reached after INIT plus WIDTH squarings.
- Selects are 11 in IDLE and DONE.
- start while busy or in DONE: ignored; the captured exponent is not disturbed.
- mul_done outside WAIT: ignored, with no state change and no load_result.

## Timing
- Reset (async, any state, including mid-operation):
  - state goes to IDLE.
  - mul_start=0, load_result=0, busy=0, done=0.
  - sel_a=sel_b=11; bit counter and exponent register are cleared.
  - A multiplier operation in flight is abandoned; its later mul_done is ignored.
- Cycle accounting: the start edge is cycle 0. Cycle 1 is the first ISSUE.
- Each operation costs 1 ISSUE cycle plus m WAIT cycles, where m ≥ 1 is the cycle in which mul_done is first seen high.
- load_result is asserted in the same cycle as the sampled mul_done, with selects still valid. R captures on that edge.
- The next op's ISSUE is the immediately following cycle; there is no idle gap.
- With a 1-cycle multiplier (mul_done the cycle after mul_start), N operations end with DONE in cycle 2N+1.
- mul_done held high across several WAIT cycles counts once. The controller leaves WAIT on the first one.
- A new start is accepted in the first IDLE cycle after DONE.

## Test plan
- Reset mid-WAIT (start, exponent=10'h155, assert rst in cycle 4) -> all outputs at reset values immediately (asynchronously). A subsequent stray mul_done produces no load_result. A new start with exponent=10'h000 runs normally.
- Exponent=10'h000, 1-cycle multiplier model -> 11 mul_start pulses. Selects (00,00) then 10×(10,10). 11 load_result pulses. done in cycle 23 and busy low thereafter.
- Exponent=10'h201, 1-cycle model -> select sequence INIT, SQ, MUL, SQ×9, MUL (13 ops). done in cycle 27. Reference model of R (mod-free integer with M=3) matches 3^513 bit-trace of ops.
- Exponent=10'h3FF, multiplier latency randomized 1–5 cycles -> 21 ops, alternating SQ/MUL after INIT. Selects stable during each WAIT. Exactly one load_result per mul_start.
- Spurious inputs -> start pulsed during WAIT and DONE is ignored (exponent register unchanged). mul_done pulsed during ISSUE and IDLE yields no load_result and no state change.
